// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch front end for the single-cycle datapath. Owns the fetch
// PC, issues word reads to a synchronous instruction memory (one-cycle read
// latency) and buffers the returned words with their PCs in a 2-entry FIFO.
// A redirect reloads the fetch PC and discards every word that has been
// fetched but not yet delivered, including a word still in flight.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   imem_req     read request to instruction memory this cycle
//   imem_addr    word address of the request (fpc[IMEM_AW+1:2])
//   imem_rdata   read data, valid the cycle after an accepted request
//   redirect     load redirect_pc into the fetch PC and flush
//   redirect_pc  redirect target byte address (low 2 bits ignored)
//   inst_ready   downstream consumes the head instruction this cycle
//   inst_valid   queue head valid
//   Inst_code    head instruction word, 0 (NOP) when empty
//   inst_pc      byte PC of the head instruction, 0 when empty
//   fetch_cnt    delivered-instruction counter, wraps
// ---------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               inst_ready,
    output logic               inst_valid,
    output logic [31:0]        Inst_code,
    output logic [31:0]        inst_pc,
    output logic [15:0]        fetch_cnt
);

    logic [31:0] fpc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic [1:0]  count;
    logic [31:0] q_word [2];   // entry 0 is always the head
    logic [31:0] q_pc   [2];

    logic        pop;
    logic        pop_eff;      // pop that actually retires (not during redirect)
    logic        wr_en;        // returning word is written into the queue
    logic [2:0]  occupancy;    // slots committed after this cycle's pop

    // The target's low bits are forced to zero; they are never consumed.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & inst_ready;
    assign pop_eff    = pop & ~redirect;
    assign wr_en      = inflight & ~redirect;

    // An in-flight word already owns a queue slot, so a new request is only
    // issued when a slot is still free after this cycle's pop. This keeps
    // count + inflight <= 2 and the queue can never overflow.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign imem_req  = rst & ~redirect & (occupancy < 3'd2);
    assign imem_addr = fpc[IMEM_AW+1:2];

    assign Inst_code = inst_valid ? q_word[0] : 32'h0000_0000;
    assign inst_pc   = inst_valid ? q_pc[0]   : 32'h0000_0000;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc       <= PC_RESET;
            count     <= 2'd0;
            inflight  <= 1'b0;
            fetch_cnt <= 16'd0;
        end else if (redirect) begin
            // Redirect wins over everything: drop queue, in-flight word and pop.
            fpc      <= {redirect_pc[31:2], 2'b00};
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (imem_req) begin
                fpc <= fpc + 32'd4;
            end
            inflight <= imem_req;
            case ({wr_en, pop_eff})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;       // idle, or write+pop
            endcase
            if (pop_eff) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
        end
    end

    // NOTE: the queue payload and inflight_pc are deliberately not reset;
    // they are only observable through count/inflight, which are reset, and
    // the head outputs are gated to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            inflight_pc <= fpc;
        end
        if (wr_en) begin
            if (pop_eff) begin
                if (count == 2'd2) begin
                    q_word[0] <= q_word[1];
                    q_pc[0]   <= q_pc[1];
                    q_word[1] <= imem_rdata;
                    q_pc[1]   <= inflight_pc;
                end else begin
                    q_word[0] <= imem_rdata;
                    q_pc[0]   <= inflight_pc;
                end
            end else if (count == 2'd0) begin
                q_word[0] <= imem_rdata;
                q_pc[0]   <= inflight_pc;
            end else begin
                // count is 1 here; a write with count 2 and no pop cannot occur.
                q_word[1] <= imem_rdata;
                q_pc[1]   <= inflight_pc;
            end
        end else if (pop_eff) begin
            q_word[0] <= q_word[1];
            q_pc[0]   <= q_pc[1];
        end
    end

endmodule
